// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: renderer fetches win outside vblank, queued CPU accesses fill idle slots.
// Optional starvation guard: define VRAM_ARB_STARVE_GUARD_EN to force a CPU slot after MAX_WAIT denials.
module vram_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16,
  parameter int MAX_WAIT   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vblank,
  input  logic              render_req,
  input  logic [ADDR_W-1:0] render_addr,
  output logic              render_data_valid,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [7:0]        cpu_req_wdata,
  output logic              cpu_rd_valid,
  output logic [7:0]        cpu_rd_data,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [7:0]        vram_wdata,
  input  logic [7:0]        vram_rdata,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(16'h3FFF);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MAX_WAIT < 1)
  begin : g_param_check
    $error("vram_arbiter: unsupported FIFO_DEPTH or MAX_WAIT");
  end

  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              fifo_we_q    [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_q  [FIFO_DEPTH];
  logic [7:0]        fifo_wdata_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_d;
  logic [7:0]        wdata_d;
  logic              render_vld_q, rd_vld_q;
  logic [7:0]        rd_data_q;
  logic              push, pop, render_want, render_gnt, cpu_can, starve;

  // Ready comes from the registered count, so a pop never frees a slot for the same cycle's push.
  assign cpu_req_ready = (count_q < CNT_W'(FIFO_DEPTH));
  assign push          = cpu_req_valid && cpu_req_ready;
  assign render_want   = !vblank && render_req;
  assign cpu_can       = (count_q != '0) && (state_q == IDLE);
  assign count_d       = count_q + CNT_W'(push) - CNT_W'(pop);

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;

  assign starve = (wait_q == WAIT_W'(MAX_WAIT));

  always_comb begin
    wait_d = wait_q;
    if (pop)
      wait_d = '0;
    else if (cpu_can && render_want)
      wait_d = wait_q + WAIT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end
`else
  assign starve = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    wdata_d    = 8'h00;
    pop        = 1'b0;
    render_gnt = 1'b0;
    // RD_WAIT lasts exactly one cycle; a render grant may share it.
    if (state_q == RD_WAIT)
      state_d = IDLE;
    if (render_want && !(starve && cpu_can)) begin
      render_gnt = 1'b1;
      addr_d     = render_addr & ADDR_MASK;
    end else if (cpu_can) begin
      pop    = 1'b1;
      addr_d = fifo_addr_q[rd_ptr_q];
      if (fifo_we_q[rd_ptr_q]) begin
        we_d    = 1'b1;
        wdata_d = fifo_wdata_q[rd_ptr_q];
      end else begin
        state_d = RD_WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we_q[wr_ptr_q]    <= cpu_req_we;
      fifo_addr_q[wr_ptr_q]  <= cpu_req_addr & ADDR_MASK;
      fifo_wdata_q[wr_ptr_q] <= cpu_req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      addr_q       <= '0;
      render_vld_q <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_q + PTR_W'(push);
      rd_ptr_q     <= rd_ptr_q + PTR_W'(pop);
      count_q      <= count_d;
      addr_q       <= addr_d;
      render_vld_q <= render_gnt;
      rd_vld_q     <= (state_q == RD_WAIT);
      if (state_q == RD_WAIT)
        rd_data_q <= vram_rdata;
    end
  end

  assign render_data_valid = render_vld_q;
  assign cpu_rd_valid      = rd_vld_q;
  assign cpu_rd_data       = rd_data_q;
  assign vram_addr         = addr_d;
  assign vram_we           = we_d;
  assign vram_wdata        = wdata_d;
  assign busy              = (count_q != '0) || (state_q == RD_WAIT);

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: scoreboarded CPU writes/reads against a synchronous VRAM model.
module tb_vram_arbiter;
  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 16;
  localparam int MAX_WAIT   = 16;

  logic        clk = 1'b0;
  logic        reset, vblank, render_req;
  logic [15:0] render_addr;
  logic        render_data_valid;
  logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [15:0] cpu_req_addr;
  logic [7:0]  cpu_req_wdata;
  logic        cpu_rd_valid;
  logic [7:0]  cpu_rd_data;
  logic [15:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic        busy;

  always #5 clk = ~clk;

  vram_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .vblank(vblank), .render_req(render_req),
    .render_addr(render_addr), .render_data_valid(render_data_valid),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata), .busy(busy)
  );

  // Synchronous single-port VRAM, 1-cycle read latency
  logic [7:0] vmem [16384];
  always @(posedge clk) begin
    if (vram_we) vmem[vram_addr[13:0]] <= vram_wdata;
    vram_rdata <= vmem[vram_addr[13:0]];
  end

  typedef struct packed { logic [13:0] addr; logic [7:0] data; } wr_t;
  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] ref_mem [int];

  int passed = 0;
  int total  = 0;

  logic        s_we, s_rd_valid, s_rvld, s_ready, s_busy;
  logic [15:0] s_addr;
  logic [7:0]  s_wdata, s_rd_data;

  // One clock: sample at negedge, settle scoreboard, return 1 time unit after the next posedge.
  task automatic tick();
    wr_t        e;
    logic [7:0] d;
    @(negedge clk);
    s_we = vram_we; s_addr = vram_addr; s_wdata = vram_wdata;
    s_rd_valid = cpu_rd_valid; s_rd_data = cpu_rd_data;
    s_rvld = render_data_valid; s_ready = cpu_req_ready; s_busy = busy;
    if (s_we) begin
      total++;
      if (exp_wr.size() == 0) begin
        $display("FAIL sb_write: unexpected write addr=%h data=%h, required no write", s_addr, s_wdata);
      end else begin
        e = exp_wr.pop_front();
        if ({s_addr, s_wdata} !== {2'b00, e.addr, e.data})
          $display("FAIL sb_write: got addr=%h data=%h, required addr=%h data=%h",
                   s_addr, s_wdata, {2'b00, e.addr}, e.data);
        else passed++;
      end
    end
    if (s_rd_valid) begin
      total++;
      if (exp_rd.size() == 0) begin
        $display("FAIL sb_read: unexpected cpu_rd_valid data=%h, required none", s_rd_data);
      end else begin
        d = exp_rd.pop_front();
        if (s_rd_data !== d) $display("FAIL sb_read: got %h, required %h", s_rd_data, d);
        else passed++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic we, input logic [15:0] addr, input logic [7:0] data);
    int n;
    int a;
    n = 0;
    a = int'(addr[13:0]);
    cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = addr; cpu_req_wdata = data;
    while (!cpu_req_ready && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (n >= 50) begin
      $display("FAIL push_timeout: addr=%h still not accepted after %0d cycles, required acceptance", addr, n);
    end else begin
      passed++;
      if (we) begin
        exp_wr.push_back({addr[13:0], data});
        ref_mem[a] = data;
      end else begin
        exp_rd.push_back(ref_mem.exists(a) ? ref_mem[a] : 8'hxx);
      end
      tick();
    end
    cpu_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; vblank = 1'b1; render_req = 1'b0; render_addr = '0;
    cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    total++;
    if ({s_ready, s_we, s_rd_valid, s_rvld, s_busy} !== 5'b10000)
      $display("FAIL reset_ctrl: ready/we/rd_valid/rvld/busy=%b, required 10000",
               {s_ready, s_we, s_rd_valid, s_rvld, s_busy});
    else passed++;
    total++;
    if ({s_addr, s_wdata, s_rd_data} !== 32'h0)
      $display("FAIL reset_data: addr=%h wdata=%h rd_data=%h, required all 0", s_addr, s_wdata, s_rd_data);
    else passed++;
  endtask

  task automatic test_write_read();
    vblank = 1'b1;
    push_req(1'b1, 16'h2005, 8'hAB);
    tick();
    total++;
    if ({s_we, s_addr, s_wdata} !== {1'b1, 16'h2005, 8'hAB})
      $display("FAIL t1_write_issue: we=%b addr=%h data=%h, required 1 2005 ab", s_we, s_addr, s_wdata);
    else passed++;
    push_req(1'b0, 16'h2005, 8'h00);
    tick();
    total++;
    if ({s_we, s_addr, s_busy} !== {1'b0, 16'h2005, 1'b1})
      $display("FAIL t1_read_issue: we=%b addr=%h busy=%b, required 0 2005 1", s_we, s_addr, s_busy);
    else passed++;
    tick();
    total++;
    if (s_rd_valid !== 1'b0) $display("FAIL t1_rd_wait: rd_valid=%b, required 0", s_rd_valid);
    else passed++;
    tick();
    total++;
    if ({s_rd_valid, s_rd_data} !== {1'b1, 8'hAB})
      $display("FAIL t1_rd_return: valid=%b data=%h, required 1 ab", s_rd_valid, s_rd_data);
    else passed++;
    // read-after-write to the same address, pushed back to back
    push_req(1'b1, 16'h1234, 8'h5C);
    push_req(1'b0, 16'h1234, 8'h00);
    repeat (4) tick();
    total++;
    if (exp_rd.size() != 0) $display("FAIL t1_raw_drained: %0d reads pending, required 0", exp_rd.size());
    else passed++;
  endtask

  task automatic test_render_block();
    int seen;
    vblank = 1'b0; render_req = 1'b1; render_addr = 16'h0123;
    for (int i = 0; i < 4; i++) push_req(1'b1, 16'h0300 + 16'(i), 8'h10 + 8'(i));
    total++;
    if (cpu_req_ready !== 1'b0) $display("FAIL t2_full_ready: ready=%b, required 0", cpu_req_ready);
    else passed++;
    seen = 0;
    repeat (5) begin
      tick();
      if (s_we) seen++;
    end
    total++;
    if ({seen, s_addr, s_rvld, s_busy} !== {32'd0, 16'h0123, 1'b1, 1'b1})
      $display("FAIL t2_render_hold: cpu_writes=%0d addr=%h rvld=%b busy=%b, required 0 0123 1 1",
               seen, s_addr, s_rvld, s_busy);
    else passed++;
    render_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({s_we, s_addr} !== {1'b1, 16'h0300 + 16'(i)})
        $display("FAIL t2_issue_order: we=%b addr=%h, required 1 %h", s_we, s_addr, 16'h0300 + 16'(i));
      else passed++;
    end
    tick();
    total++;
    if ({s_we, s_ready, s_busy} !== 3'b010)
      $display("FAIL t2_drained: we/ready/busy=%b, required 010", {s_we, s_ready, s_busy});
    else passed++;
  endtask

  task automatic test_addr_mask();
    vblank = 1'b1;
    push_req(1'b1, 16'h7FFF, 8'h3C);
    tick();
    total++;
    if ({s_we, s_addr} !== {1'b1, 16'h3FFF})
      $display("FAIL t3_cpu_mask: we=%b addr=%h, required 1 3fff", s_we, s_addr);
    else passed++;
    vblank = 1'b0; render_req = 1'b1; render_addr = 16'hC010;
    tick();
    total++;
    if ({s_we, s_addr} !== {1'b0, 16'h0010})
      $display("FAIL t3_render_mask: we=%b addr=%h, required 0 0010", s_we, s_addr);
    else passed++;
    render_req = 1'b0;
    tick();
    total++;
    if ({s_rvld, s_addr} !== {1'b1, 16'h0010})
      $display("FAIL t3_rvld_hold: rvld=%b addr=%h, required 1 0010", s_rvld, s_addr);
    else passed++;
  endtask

  task automatic test_vblank_edges();
    vblank = 1'b1; render_req = 1'b0;
    push_req(1'b1, 16'h0456, 8'h77);
    tick();
    push_req(1'b0, 16'h0456, 8'h00);
    tick();
    total++;
    if ({s_we, s_addr} !== {1'b0, 16'h0456})
      $display("FAIL t4_read_issue: we=%b addr=%h, required 0 0456", s_we, s_addr);
    else passed++;
    vblank = 1'b0; render_req = 1'b1; render_addr = 16'h0100;
    tick();
    total++;
    if ({s_addr, s_rd_valid} !== {16'h0100, 1'b0})
      $display("FAIL t4_render_overlap: addr=%h rd_valid=%b, required 0100 0", s_addr, s_rd_valid);
    else passed++;
    render_req = 1'b0;
    tick();
    total++;
    if ({s_rd_valid, s_rd_data, s_rvld} !== {1'b1, 8'h77, 1'b1})
      $display("FAIL t4_both_valid: rd_valid=%b data=%h rvld=%b, required 1 77 1", s_rd_valid, s_rd_data, s_rvld);
    else passed++;
    // vblank rising while the renderer still requests: CPU issues that same cycle
    render_req = 1'b1;
    push_req(1'b1, 16'h0460, 8'h42);
    tick();
    vblank = 1'b1;
    tick();
    total++;
    if ({s_we, s_addr} !== {1'b1, 16'h0460})
      $display("FAIL t4_vblank_rise: we=%b addr=%h, required 1 0460", s_we, s_addr);
    else passed++;
    render_req = 1'b0;
  endtask

  task automatic test_reset_flush();
    int seen;
    vblank = 1'b0; render_req = 1'b1; render_addr = 16'h0200;
    push_req(1'b0, 16'h0456, 8'h00);
    push_req(1'b1, 16'h0500, 8'h01);
    push_req(1'b1, 16'h0501, 8'h02);
    push_req(1'b1, 16'h0502, 8'h03);
    render_req = 1'b0;
    tick();
    total++;
    if ({s_we, s_addr} !== {1'b0, 16'h0456})
      $display("FAIL t5_read_issue: we=%b addr=%h, required 0 0456", s_we, s_addr);
    else passed++;
    reset = 1'b1;
    exp_wr.delete();
    exp_rd.delete();
    tick();
    reset = 1'b0;
    tick();
    total++;
    if ({s_ready, s_busy, s_rd_valid} !== 3'b100)
      $display("FAIL t5_after_reset: ready/busy/rd_valid=%b, required 100", {s_ready, s_busy, s_rd_valid});
    else passed++;
    seen = 0;
    repeat (6) begin
      tick();
      if (s_rd_valid || s_we) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL t5_flushed: %0d stale accesses, required 0", seen);
    else passed++;
  endtask

  task automatic test_starvation();
    int early;
    vblank = 1'b0; render_req = 1'b1; render_addr = 16'h0040;
    push_req(1'b1, 16'h0600, 8'h99);
    early = 0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    for (int k = 1; k <= MAX_WAIT + 2; k++) begin
      tick();
      if (k <= MAX_WAIT && s_we) early++;
      if (k == MAX_WAIT + 1) begin
        total++;
        if ({s_we, s_addr, s_rvld} !== {1'b1, 16'h0600, 1'b1})
          $display("FAIL t6_forced_issue: we=%b addr=%h rvld=%b, required 1 0600 1", s_we, s_addr, s_rvld);
        else passed++;
      end
      if (k == MAX_WAIT + 2) begin
        total++;
        if ({s_rvld, s_we} !== 2'b00)
          $display("FAIL t6_denied_fetch: rvld=%b we=%b, required 00", s_rvld, s_we);
        else passed++;
      end
    end
    total++;
    if (early != 0) $display("FAIL t6_early_issue: %0d early writes, required 0", early);
    else passed++;
    render_req = 1'b0;
`else
    repeat (MAX_WAIT + 8) begin
      tick();
      if (s_we) early++;
    end
    total++;
    if ({early, s_rvld} !== {32'd0, 1'b1})
      $display("FAIL t6_render_priority: cpu_writes=%0d rvld=%b, required 0 1", early, s_rvld);
    else passed++;
    render_req = 1'b0;
    tick();
    total++;
    if ({s_we, s_addr} !== {1'b1, 16'h0600})
      $display("FAIL t6_release_issue: we=%b addr=%h, required 1 0600", s_we, s_addr);
    else passed++;
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_render_block();
    test_addr_mask();
    test_vblank_edges();
    test_reset_flush();
    test_starvation();
    total++;
    if (exp_wr.size() != 0 || exp_rd.size() != 0)
      $display("FAIL sb_drained: %0d writes %0d reads pending, required 0 0", exp_wr.size(), exp_rd.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port VRAM between the background/sprite renderer and the CPU-side PPU register interface.
- Replaces the plain vblank address mux with a scheduled arbiter:
  - CPU reads/writes are queued in a small FIFO.
  - Queued requests are issued in cycles the renderer does not need VRAM.
  - Read data returns to the register interface with a valid pulse.
- Sits between ppu_reg, ppu_render and VRAM inside the PPU top level.

Parameters:
- FIFO_DEPTH, 4, CPU request queue entries (power of two, 2..16).
- ADDR_W, 16, VRAM address width; issued addresses masked to 14 bits (0x0000-0x3FFF).
- MAX_WAIT, 16, starvation limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- vblank  in  1  high = rendering idle, CPU owns VRAM freely
- render_req  in  1  renderer needs VRAM this cycle
- render_addr  in  ADDR_W  renderer fetch address
- render_data_valid  out  1  renderer read data valid (one cycle after a granted render_req)
- cpu_req_valid  in  1  CPU request offered
- cpu_req_ready  out  1  FIFO can accept
- cpu_req_we  in  1  1 = write, 0 = read
- cpu_req_addr  in  ADDR_W  CPU VRAM address
- cpu_req_wdata  in  8  CPU write data
- cpu_rd_valid  out  1  one-cycle pulse, cpu_rd_data valid
- cpu_rd_data  out  8  read data for the oldest CPU read
- vram_addr  out  ADDR_W  VRAM address
- vram_we  out  1  VRAM write enable
- vram_wdata  out  8  VRAM write data
- vram_rdata  in  8  VRAM read data (synchronous, 1-cycle latency)
- busy  out  1  FIFO non-empty or read in flight

Behaviour:
Reset:
- FIFO flushed; any in-flight read dropped.
- All outputs 0, except cpu_req_ready = 1 on the first cycle after reset.

Handshake:
- Push occurs when cpu_req_valid && cpu_req_ready.
- cpu_req_ready = (count < FIFO_DEPTH), computed from the registered count.
- A pop in the same cycle does not free a slot for that cycle's push.

Grant, evaluated each cycle:
- RENDER when !vblank && render_req:
  - vram_addr = render_addr & 0x3FFF, vram_we = 0.
  - render_data_valid = 1 on the next cycle.
- Otherwise CPU when the FIFO is non-empty and the state is IDLE:
  - Head popped; vram_addr = head.addr & 0x3FFF.
  - Write: vram_we = 1, vram_wdata = head.wdata, completes in 1 cycle, state stays IDLE.
  - Read: vram_we = 0, state goes to RD_WAIT.
- Otherwise no access: vram_we = 0, vram_addr holds its last value.

States:
- IDLE: as described under Grant.
- RD_WAIT: vram_rdata captured into cpu_rd_data; cpu_rd_valid = 1 for one cycle; return to IDLE the following cycle.
  - A render grant may overlap RD_WAIT, because the capture uses the data from the previous cycle's address.
  - No new CPU request issues while in RD_WAIT.

Ordering and latency:
- CPU requests complete strictly in FIFO order.
- Read-after-write to the same address returns the new data.
- Minimum CPU read latency, push to cpu_rd_valid, is 3 cycles: enqueue, issue, capture.

Boundary conditions:
- Full FIFO: cpu_req_ready = 0; requests are held by the source, never dropped.
- Empty FIFO: no CPU access; busy = 0 when the FIFO is empty and the state is IDLE.
- vblank rising mid-stream: CPU issue starts in the same cycle.
- vblank falling with a read in RD_WAIT: the capture still completes.
- Pointer wrap: modulo FIFO_DEPTH; count is 0..FIFO_DEPTH inclusive.

Optional Feature:
- Macro: VRAM_ARB_STARVE_GUARD_EN.
- With the macro defined:
  - A wait counter increments each cycle the FIFO is non-empty and the CPU is denied by the renderer.
  - When the counter reaches MAX_WAIT, the next cycle grants the CPU even if render_req is high.
  - That cycle render_data_valid stays 0 for the denied fetch; the renderer must retry.
  - The counter clears on any CPU issue or on reset.
- Without the macro: the renderer has absolute priority outside vblank, and no counter exists.

Test Plan:
1. Reset, vblank = 1; push write 0x2005 <- 0xAB, then read 0x2005 -> vram_we pulse with addr 0x2005 / data 0xAB; cpu_rd_valid with cpu_rd_data = 0xAB exactly 2 cycles after the read issues.
2. vblank = 0, render_req held high; push 4 CPU writes -> cpu_req_ready = 0 after the 4th; no CPU access until render_req drops; then 4 writes issue in order on consecutive cycles.
3. Address 0x7FFF write -> vram_addr = 0x3FFF.
4. Read issued in the last vblank cycle, then render_req high on the next cycle -> both cpu_rd_valid and render_data_valid correct; no data corruption.
5. Assert reset with 3 queued requests and a read in RD_WAIT -> cpu_rd_valid never pulses; count = 0; cpu_req_ready = 1 the next cycle.
6. With VRAM_ARB_STARVE_GUARD_EN, render_req constantly high, 1 queued write -> write issues exactly on cycle MAX_WAIT + 1 after the push, with render_data_valid = 0 on the following cycle.
